// File: rtl/voice_allocator_if.sv
// Note-command channel into the voice allocator: a valid strobe and a
// packed {on, note, vel} word that is sampled only while the strobe is high.
interface voice_allocator_if #(
  parameter int NOTE_W = 7,
  parameter int VEL_W  = 8
);
  logic                    i_valid;
  logic [NOTE_W+VEL_W:0]   i_data;

  modport master (output i_valid, output i_data);
  modport slave  (input  i_valid, input  i_data);
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note on/off commands onto VOICES slots with
// retrigger on duplicate notes and idle > oldest-release > oldest-active stealing.
module voice_allocator #(
  parameter int VOICES     = 8,
  parameter int NOTE_W     = 7,
  parameter int VEL_W      = 8,
  parameter int AGE_W      = 8,
  parameter int REL_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        i_reset_n,
  voice_allocator_if.slave            cmd,
  output logic [VOICES-1:0]           o_gate,
  output logic [VOICES-1:0]           o_busy,
  output logic [VOICES*NOTE_W-1:0]    o_notes,
  output logic [VOICES*VEL_W-1:0]     o_vels,
  output logic [VOICES-1:0]           o_trig,
  output logic                        o_stolen,
  output logic [$clog2(VOICES+1)-1:0] o_voice_cnt
);

  localparam int IDX_W = $clog2(VOICES);
  localparam int CNT_W = $clog2(VOICES+1);
  localparam int REL_W = (REL_CYCLES > 0) ? $clog2(REL_CYCLES+1) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } voice_state_t;

  voice_state_t       state_reg [VOICES];
  voice_state_t       state_next[VOICES];
  logic [AGE_W-1:0]   age_reg   [VOICES];
  logic [AGE_W-1:0]   age_next  [VOICES];
  logic [REL_W-1:0]   rel_reg   [VOICES];
  logic [REL_W-1:0]   rel_next  [VOICES];
  logic [NOTE_W-1:0]  note_reg  [VOICES];
  logic [NOTE_W-1:0]  note_next [VOICES];
  logic [VEL_W-1:0]   vel_reg   [VOICES];
  logic [VEL_W-1:0]   vel_next  [VOICES];

  logic [VOICES-1:0]  gate_reg, gate_next;
  logic [VOICES-1:0]  busy_reg, busy_next;
  logic [VOICES-1:0]  trig_reg, trig_next;
  logic               stolen_reg, stolen_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic               cmd_on;
  logic [NOTE_W-1:0]  cmd_note;
  logic [VEL_W-1:0]   cmd_vel;
  logic               start_cmd;
  logic               stop_cmd;

  assign cmd_on    = cmd.i_data[NOTE_W+VEL_W];
  assign cmd_note  = cmd.i_data[VEL_W +: NOTE_W];
  assign cmd_vel   = cmd.i_data[VEL_W-1:0];
  // A note-on with zero velocity is a note-off in disguise.
  assign start_cmd = cmd.i_valid && cmd_on && (cmd_vel != '0);
  assign stop_cmd  = cmd.i_valid && !(cmd_on && (cmd_vel != '0));

  // Candidate search over the registered state; strict '>' keeps age ties on the lowest index.
  logic               match_found, idle_found, rel_found, act_found;
  logic [IDX_W-1:0]   match_idx, idle_idx, rel_idx, act_idx;
  logic [AGE_W-1:0]   rel_age, act_age;
  logic [IDX_W-1:0]   target_idx;
  logic               steal;

  always_comb begin
    match_found = 1'b0;
    idle_found  = 1'b0;
    rel_found   = 1'b0;
    act_found   = 1'b0;
    match_idx   = '0;
    idle_idx    = '0;
    rel_idx     = '0;
    act_idx     = '0;
    rel_age     = '0;
    act_age     = '0;
    for (int k = 0; k < VOICES; k++) begin
      if (!match_found && state_reg[k] != ST_IDLE && note_reg[k] == cmd_note) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(k);
      end
      if (!idle_found && state_reg[k] == ST_IDLE) begin
        idle_found = 1'b1;
        idle_idx   = IDX_W'(k);
      end
      if (state_reg[k] == ST_RELEASE && (!rel_found || age_reg[k] > rel_age)) begin
        rel_found = 1'b1;
        rel_idx   = IDX_W'(k);
        rel_age   = age_reg[k];
      end
      if (state_reg[k] == ST_ACTIVE && (!act_found || age_reg[k] > act_age)) begin
        act_found = 1'b1;
        act_idx   = IDX_W'(k);
        act_age   = age_reg[k];
      end
    end
  end

  always_comb begin
    steal = 1'b0;
    if (match_found) begin
      target_idx = match_idx;
    end else if (idle_found) begin
      target_idx = idle_idx;
    end else if (rel_found) begin
      target_idx = rel_idx;
    end else begin
      target_idx = act_idx;
      steal      = act_found;
    end
  end

  // Per-voice next state: a command hit overrides the free-running age/release progress.
  always_comb begin
    gate_next   = '0;
    busy_next   = '0;
    trig_next   = '0;
    cnt_next    = '0;
    stolen_next = start_cmd && steal;
    for (int k = 0; k < VOICES; k++) begin
      state_next[k] = state_reg[k];
      age_next[k]   = (age_reg[k] == AGE_MAX) ? age_reg[k] : age_reg[k] + AGE_W'(1);
      rel_next[k]   = rel_reg[k];
      note_next[k]  = note_reg[k];
      vel_next[k]   = vel_reg[k];

      if (state_reg[k] == ST_RELEASE) begin
        if (rel_reg[k] <= REL_W'(1)) begin
          state_next[k] = ST_IDLE;
          rel_next[k]   = '0;
        end else begin
          rel_next[k]   = rel_reg[k] - REL_W'(1);
        end
      end

      if (start_cmd && target_idx == IDX_W'(k)) begin
        state_next[k] = ST_ACTIVE;
        age_next[k]   = '0;
        rel_next[k]   = '0;
        note_next[k]  = cmd_note;
        vel_next[k]   = cmd_vel;
        trig_next[k]  = 1'b1;
      end else if (stop_cmd && state_reg[k] == ST_ACTIVE && note_reg[k] == cmd_note) begin
        if (REL_CYCLES == 0) begin
          state_next[k] = ST_IDLE;
        end else begin
          state_next[k] = ST_RELEASE;
          rel_next[k]   = REL_W'(REL_CYCLES);
        end
      end

      gate_next[k] = (state_next[k] == ST_ACTIVE);
      busy_next[k] = (state_next[k] != ST_IDLE);
      cnt_next     = cnt_next + CNT_W'(busy_next[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      for (int k = 0; k < VOICES; k++) begin
        state_reg[k] <= ST_IDLE;
        age_reg[k]   <= '0;
        rel_reg[k]   <= '0;
        note_reg[k]  <= '0;
        vel_reg[k]   <= '0;
      end
      gate_reg   <= '0;
      busy_reg   <= '0;
      trig_reg   <= '0;
      stolen_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      for (int k = 0; k < VOICES; k++) begin
        state_reg[k] <= state_next[k];
        age_reg[k]   <= age_next[k];
        rel_reg[k]   <= rel_next[k];
        note_reg[k]  <= note_next[k];
        vel_reg[k]   <= vel_next[k];
      end
      gate_reg   <= gate_next;
      busy_reg   <= busy_next;
      trig_reg   <= trig_next;
      stolen_reg <= stolen_next;
      cnt_reg    <= cnt_next;
    end
  end

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_pack
    assign o_notes[gi*NOTE_W +: NOTE_W] = note_reg[gi];
    assign o_vels[gi*VEL_W +: VEL_W]    = vel_reg[gi];
  end

  assign o_gate      = gate_reg;
  assign o_busy      = busy_reg;
  assign o_trig      = trig_reg;
  assign o_stolen    = stolen_reg;
  assign o_voice_cnt = cnt_reg;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with 4 voices and a 4-cycle release.
module tb_voice_allocator;

  localparam int VOICES = 4;
  localparam int NOTE_W = 7;
  localparam int VEL_W  = 8;

  logic                clk = 1'b0;
  logic                i_reset_n;
  logic [VOICES-1:0]   o_gate, o_busy, o_trig;
  logic [VOICES*NOTE_W-1:0] o_notes;
  logic [VOICES*VEL_W-1:0]  o_vels;
  logic                o_stolen;
  logic [2:0]          o_voice_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  voice_allocator_if #(.NOTE_W(NOTE_W), .VEL_W(VEL_W)) cif ();

  voice_allocator #(
    .VOICES(VOICES), .NOTE_W(NOTE_W), .VEL_W(VEL_W), .AGE_W(8), .REL_CYCLES(4)
  ) dut (
    .clk(clk),
    .i_reset_n(i_reset_n),
    .cmd(cif),
    .o_gate(o_gate),
    .o_busy(o_busy),
    .o_notes(o_notes),
    .o_vels(o_vels),
    .o_trig(o_trig),
    .o_stolen(o_stolen),
    .o_voice_cnt(o_voice_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [NOTE_W-1:0] note_of(input int k);
    return o_notes[k*NOTE_W +: NOTE_W];
  endfunction

  function automatic logic [VEL_W-1:0] vel_of(input int k);
    return o_vels[k*VEL_W +: VEL_W];
  endfunction

  // One command per call; returns 1 time unit after the sampling edge.
  task automatic drive(input logic on, input logic [NOTE_W-1:0] note, input logic [VEL_W-1:0] vel);
    @(negedge clk);
    cif.i_valid = 1'b1;
    cif.i_data  = {on, note, vel};
    @(posedge clk);
    #1;
    cif.i_valid = 1'b0;
    $display("cmd on=%0d note=%0d vel=0x%02h -> gate=%b busy=%b trig=%b stolen=%b cnt=%0d",
             on, note, vel, o_gate, o_busy, o_trig, o_stolen, o_voice_cnt);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    i_reset_n = 1'b0;
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    i_reset_n   = 1'b0;
    cif.i_valid = 1'b0;
    cif.i_data  = '0;
    idle(2);
    i_reset_n = 1'b1;
    $display("reset applied");
    n_checks++; if (o_gate !== 4'b0000) begin n_fail++; $display("FAIL reset_gate: got %b want 0000", o_gate); end
    n_checks++; if (o_busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy: got %b want 0000", o_busy); end
    n_checks++; if (o_trig !== 4'b0000) begin n_fail++; $display("FAIL reset_trig: got %b want 0000", o_trig); end
    n_checks++; if (o_stolen !== 1'b0) begin n_fail++; $display("FAIL reset_stolen: got %b want 0", o_stolen); end
    n_checks++; if (o_voice_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", o_voice_cnt); end
    n_checks++; if (o_notes !== '0 || o_vels !== '0) begin n_fail++; $display("FAIL reset_notes_vels: got %h/%h want 0/0", o_notes, o_vels); end
  endtask

  task automatic test_start_stop();
    drive(1'b1, 7'd69, 8'h40);
    n_checks++; if (o_gate !== 4'b0001) begin n_fail++; $display("FAIL start_gate: got %b want 0001", o_gate); end
    n_checks++; if (o_trig !== 4'b0001) begin n_fail++; $display("FAIL start_trig: got %b want 0001", o_trig); end
    n_checks++; if (note_of(0) !== 7'd69) begin n_fail++; $display("FAIL start_note: got %0d want 69", note_of(0)); end
    n_checks++; if (vel_of(0) !== 8'h40) begin n_fail++; $display("FAIL start_vel: got %h want 40", vel_of(0)); end
    n_checks++; if (o_voice_cnt !== 3'd1) begin n_fail++; $display("FAIL start_cnt: got %0d want 1", o_voice_cnt); end
    idle(1);
    n_checks++; if (o_trig !== 4'b0000) begin n_fail++; $display("FAIL trig_one_cycle: got %b want 0000", o_trig); end

    drive(1'b0, 7'd69, 8'h55);
    n_checks++; if (o_gate !== 4'b0000) begin n_fail++; $display("FAIL stop_gate: got %b want 0000", o_gate); end
    n_checks++; if (o_busy !== 4'b0001) begin n_fail++; $display("FAIL stop_busy_c1: got %b want 0001", o_busy); end
    for (int c = 2; c <= 4; c++) begin
      idle(1);
      n_checks++; if (o_busy !== 4'b0001) begin n_fail++; $display("FAIL release_busy_c%0d: got %b want 0001", c, o_busy); end
    end
    idle(1);
    n_checks++; if (o_busy !== 4'b0000) begin n_fail++; $display("FAIL release_end_busy: got %b want 0000", o_busy); end
    n_checks++; if (o_voice_cnt !== 3'd0) begin n_fail++; $display("FAIL release_end_cnt: got %0d want 0", o_voice_cnt); end

    drive(1'b0, 7'd74, 8'h00);
    n_checks++; if (o_busy !== 4'b0000 || o_gate !== 4'b0000) begin n_fail++; $display("FAIL stop_absent: got busy=%b gate=%b want 0000/0000", o_busy, o_gate); end
    n_checks++; if (note_of(0) !== 7'd69 || vel_of(0) !== 8'h40) begin n_fail++; $display("FAIL idle_keeps_note: got %0d/%h want 69/40", note_of(0), vel_of(0)); end
  endtask

  task automatic test_steal();
    drive(1'b1, 7'd40, 8'h10);
    drive(1'b1, 7'd60, 8'h11);
    drive(1'b1, 7'd77, 8'h12);
    drive(1'b1, 7'd95, 8'h13);
    n_checks++; if (o_gate !== 4'b1111) begin n_fail++; $display("FAIL fill_gate: got %b want 1111", o_gate); end
    n_checks++; if (o_voice_cnt !== 3'd4) begin n_fail++; $display("FAIL fill_cnt: got %0d want 4", o_voice_cnt); end
    n_checks++; if (note_of(3) !== 7'd95) begin n_fail++; $display("FAIL fill_note3: got %0d want 95", note_of(3)); end
    idle(3);
    drive(1'b1, 7'd26, 8'h20);
    n_checks++; if (o_trig !== 4'b0001) begin n_fail++; $display("FAIL steal_trig: got %b want 0001", o_trig); end
    n_checks++; if (o_stolen !== 1'b1) begin n_fail++; $display("FAIL steal_flag: got %b want 1", o_stolen); end
    n_checks++; if (note_of(0) !== 7'd26) begin n_fail++; $display("FAIL steal_note: got %0d want 26", note_of(0)); end
    idle(1);
    n_checks++; if (o_stolen !== 1'b0) begin n_fail++; $display("FAIL steal_one_cycle: got %b want 0", o_stolen); end
  endtask

  task automatic test_release_take();
    drive(1'b0, 7'd60, 8'h00);
    n_checks++; if (o_gate !== 4'b1101 || o_busy !== 4'b1111) begin n_fail++; $display("FAIL rel_state: got gate=%b busy=%b want 1101/1111", o_gate, o_busy); end
    drive(1'b1, 7'd50, 8'h30);
    n_checks++; if (o_trig !== 4'b0010) begin n_fail++; $display("FAIL rel_take_trig: got %b want 0010", o_trig); end
    n_checks++; if (o_stolen !== 1'b0) begin n_fail++; $display("FAIL rel_take_stolen: got %b want 0", o_stolen); end
    n_checks++; if (note_of(1) !== 7'd50 || o_gate !== 4'b1111) begin n_fail++; $display("FAIL rel_take_note: got note=%0d gate=%b want 50/1111", note_of(1), o_gate); end
  endtask

  task automatic test_retrigger();
    pulse_reset();
    drive(1'b1, 7'd69, 8'h40);
    n_checks++; if (o_trig !== 4'b0001) begin n_fail++; $display("FAIL retrig_first: got %b want 0001", o_trig); end
    drive(1'b1, 7'd69, 8'h7F);
    n_checks++; if (o_trig !== 4'b0001) begin n_fail++; $display("FAIL retrig_second: got %b want 0001", o_trig); end
    n_checks++; if (vel_of(0) !== 8'h7F) begin n_fail++; $display("FAIL retrig_vel: got %h want 7f", vel_of(0)); end
    n_checks++; if (o_voice_cnt !== 3'd1 || o_gate !== 4'b0001) begin n_fail++; $display("FAIL retrig_cnt: got cnt=%0d gate=%b want 1/0001", o_voice_cnt, o_gate); end
    drive(1'b1, 7'd69, 8'h00);
    n_checks++; if (o_gate !== 4'b0000 || o_busy !== 4'b0001 || o_trig !== 4'b0000) begin n_fail++; $display("FAIL vel0_stop: got gate=%b busy=%b trig=%b want 0000/0001/0000", o_gate, o_busy, o_trig); end
    drive(1'b1, 7'd69, 8'h22);
    n_checks++; if (o_trig !== 4'b0001 || o_gate !== 4'b0001 || vel_of(0) !== 8'h22) begin n_fail++; $display("FAIL retrig_release: got trig=%b gate=%b vel=%h want 0001/0001/22", o_trig, o_gate, vel_of(0)); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 7'd10, 8'h01);
    drive(1'b1, 7'd11, 8'h02);
    n_checks++; if (o_busy !== 4'b0111 || o_voice_cnt !== 3'd3) begin n_fail++; $display("FAIL pre_reset: got busy=%b cnt=%0d want 0111/3", o_busy, o_voice_cnt); end
    @(negedge clk);
    i_reset_n   = 1'b0;
    cif.i_valid = 1'b1;
    cif.i_data  = {1'b1, 7'd13, 8'h03};
    @(posedge clk);
    #1;
    i_reset_n   = 1'b1;
    cif.i_valid = 1'b0;
    $display("reset with pending start note=13");
    n_checks++; if (o_gate !== 4'b0000 || o_busy !== 4'b0000 || o_trig !== 4'b0000) begin n_fail++; $display("FAIL midreset_flags: got gate=%b busy=%b trig=%b want zeros", o_gate, o_busy, o_trig); end
    n_checks++; if (o_voice_cnt !== 3'd0 || o_stolen !== 1'b0) begin n_fail++; $display("FAIL midreset_cnt: got cnt=%0d stolen=%b want 0/0", o_voice_cnt, o_stolen); end
    n_checks++; if (o_notes !== '0 || o_vels !== '0) begin n_fail++; $display("FAIL midreset_notes: got %h/%h want 0/0", o_notes, o_vels); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 7'd5, 8'h44);
    drive(1'b0, 7'd5, 8'h00);
    n_checks++; if (o_gate !== 4'b0000 || o_busy !== 4'b0001) begin n_fail++; $display("FAIL b2b_stop: got gate=%b busy=%b want 0000/0001", o_gate, o_busy); end
    drive(1'b1, 7'd6, 8'h45);
    n_checks++; if (o_trig !== 4'b0010 || o_gate !== 4'b0010) begin n_fail++; $display("FAIL b2b_next_voice: got trig=%b gate=%b want 0010/0010", o_trig, o_gate); end
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_steal();
    test_release_take();
    test_retrigger();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Parametrised polyphonic voice allocator between the note-command input and the per-voice oscillator banks of the synthesizer. Accepts one `{on, note, velocity}` command per valid cycle. Maps each command onto one of `VOICES` voice slots with idle / active / release states, retrigger on duplicate notes, and oldest-first voice stealing when full. It replaces the ad-hoc bank enabling driven directly from the raw command word: the strobed `i_valid` removes the need for the source to zero the word after each command.

## Interface
- `VOICES`, 8: number of voice slots (2..32).
- `NOTE_W`, 7: note number width.
- `VEL_W`, 8: velocity width.
- `AGE_W`, 8: per-voice age counter width (saturating).
- `REL_CYCLES`, 16: cycles a voice stays in RELEASE after a stop (0 allowed).

- `clk`  in  1  single clock; all logic on posedge.
- `i_reset_n`  in  1  reset, synchronous, active-low.
- `i_valid`  in  1  command strobe; `i_data` is sampled only when high.
- `i_data`  in  1+NOTE_W+VEL_W  `{on, note, vel}`; `on` is the MSB.
- `o_gate`  out  VOICES  1 = voice ACTIVE.
- `o_busy`  out  VOICES  1 = voice ACTIVE or RELEASE.
- `o_notes`  out  VOICES*NOTE_W  per-voice note; voice k at bits `[k*NOTE_W +: NOTE_W]`.
- `o_vels`  out  VOICES*VEL_W  per-voice velocity, packed the same way.
- `o_trig`  out  VOICES  one-cycle pulse on a voice start or retrigger.
- `o_stolen`  out  1  one-cycle pulse when an ACTIVE voice is stolen.
- `o_voice_cnt`  out  $clog2(VOICES+1)  number of voices with `o_busy` set.

## Operation
- Per-voice state:
  - IDLE, ACTIVE and RELEASE.
  - Age counter: cleared on (re)start, +1 every cycle, saturates at 2^AGE_W-1.
  - Release counter.
- Start (`i_valid`, `on`=1, `vel`≠0):
  - If any busy voice holds `note`, retrigger the lowest-index such voice: state → ACTIVE, `vel` updated, age → 0, `o_trig[k]`=1. No other voice changes.
  - Otherwise allocate by priority: lowest-index IDLE; else the oldest RELEASE; else the oldest ACTIVE. Stealing an ACTIVE voice also pulses `o_stolen`.
  - Age ties go to the lowest index.
  - The allocated voice gets `note`/`vel`, age 0, ACTIVE, `o_trig[k]`=1.
- Start with `vel`=0 is treated exactly as a stop.
- Stop (`i_valid`, `on`=0): every ACTIVE voice with a matching note → RELEASE and its release counter is loaded with `REL_CYCLES`. When `REL_CYCLES`=0 the voice goes directly to IDLE.
- Stop effects:
  - Stopping a note that is not playing, or that is only in RELEASE, changes nothing.
  - A stop's velocity field is ignored.
- RELEASE: the counter decrements each cycle. The voice is in RELEASE for exactly `REL_CYCLES` cycles, then IDLE.
- IDLE voices keep their last `note`/`vel` on the outputs.
- `i_valid`=0: no command effect. Ages and release counters keep running.

## Timing
- All outputs are registered. A command sampled at edge N is reflected on the outputs after edge N (visible in cycle N+1).
- `o_trig` and `o_stolen` are high for exactly that one cycle.
- Throughput is one command per cycle. There is no backpressure.
- Allocation uses the state registered before the edge. A voice whose release expires at the same edge still counts as RELEASE for that decision, and allocation overrides the expiry.
- A command targeting a voice overrides that voice's same-cycle age increment and release decrement.
- Reset (`i_reset_n`=0 at an edge):
  - All voices IDLE.
  - Ages, counters, `o_notes`, `o_vels` = 0.
  - `o_gate`, `o_busy`, `o_trig`, `o_stolen`, `o_voice_cnt` = 0.
  - Reset mid-release or mid-command wins over any command in the same cycle.
- `o_voice_cnt` is registered and consistent with `o_busy` in the same cycle.

## Test plan
- Bench parameters: `VOICES`=4, `REL_CYCLES`=4.
- Reset, then start A4 (note 69, vel 0x40) → next cycle `o_gate`=0001, `o_trig`=0001, `o_notes[6:0]`=69, `o_voice_cnt`=1.
- Stop note 69 → `o_gate`=0000, `o_busy`=0001 for exactly 4 cycles, then 0000. A stop of note 74 (not playing) changes no output.
- Start notes 40, 60, 77, 95 on consecutive cycles → `o_gate`=1111. Start 26 four cycles later → voice 0 (oldest, note 40) is reused, `o_stolen`=1, `o_trig`=0001.
- With voice 1 in RELEASE and voices 0, 2, 3 ACTIVE, start a new note → voice 1 is taken and `o_stolen`=0.
- Start 69 with vel 0x40, then start 69 with vel 0x7F → same voice, `o_trig` pulses twice, `o_vels`=0x7F, `o_voice_cnt`=1. Start 69 with vel 0 → that voice enters RELEASE.
- Drive `i_reset_n`=0 for one cycle while 3 voices are busy and a start is valid → all outputs 0 on the following cycle.
